jesd204b_tpl_rx: RTL and testbench

Receive-side JESD204B transport layer. It takes one frame per cycle of lane octets from the RX data link layer and un-maps it into per-converter samples and control bits. The mapping is the exact inverse of the transmit transport layer, and the block also checks tail and padding integrity. It sits between the RX link layer (lane data, frame valid) and the converter sample sinks.

---
 rtl/jesd204b_tpl_pkg.sv | 34 +++
 rtl/jesd204b_tpl_rx_slot.sv | 29 ++
 rtl/jesd204b_tpl_rx.sv | 119 +++++++++++
 tb/tb_jesd204b_tpl_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_tpl_pkg.sv
// Shared JESD204B transport-layer parameter math and legality checks (RX and TX).
package jesd204b_tpl_pkg;

  localparam int unsigned SLOT_W = 16;

  // Converter count rounded up to a whole number of slots per lane
  function automatic int unsigned tpl_cp(input int unsigned lanes, input int unsigned converters);
    if (lanes == 0) return 0;
    return ((converters + lanes - 1) / lanes) * lanes;
  endfunction

  function automatic int unsigned tpl_octets(input int unsigned lanes, input int unsigned converters);
    if (lanes == 0) return 0;
    return (2 * tpl_cp(lanes, converters)) / lanes;
  endfunction

  function automatic int unsigned tpl_tails(input int unsigned sample_size,
                                            input int unsigned resolution,
                                            input int unsigned control);
    return sample_size - resolution - control;
  endfunction

  function automatic bit tpl_params_legal(input int unsigned lanes,
                                          input int unsigned converters,
                                          input int unsigned resolution,
                                          input int unsigned control,
                                          input int unsigned sample_size,
                                          input int unsigned samples);
    return (lanes >= 1) && (converters >= 1) && (control >= 1) &&
           (resolution >= 9) && (resolution + control <= SLOT_W) &&
           (sample_size == SLOT_W) && (samples == 1);
  endfunction

endpackage

// File: rtl/jesd204b_tpl_rx_slot.sv
// Combinational split of one 16-bit transport slot into sample, control and tail check.
// Padding slots flag any nonzero bit instead of just the tail bits.
module jesd204b_tpl_rx_slot
  import jesd204b_tpl_pkg::*;
#(
  parameter int unsigned RESOLUTION = 11,
  parameter int unsigned CONTROL    = 2,
  parameter bit          PAD        = 1'b0
) (
  input  logic [SLOT_W-1:0]     slot_i,
  output logic [RESOLUTION-1:0] sample_o,
  output logic [CONTROL-1:0]    ctrl_o,
  output logic                  tail_nz_o
);

  localparam int unsigned TAILS = tpl_tails(SLOT_W, RESOLUTION, CONTROL);

  assign sample_o = slot_i[SLOT_W-1 -: RESOLUTION];
  assign ctrl_o   = slot_i[SLOT_W-1-RESOLUTION -: CONTROL];

  if (PAD) begin : g_pad
    assign tail_nz_o = |slot_i;
  end else if (TAILS > 0) begin : g_tail
    assign tail_nz_o = |slot_i[TAILS-1:0];
  end else begin : g_no_tail
    assign tail_nz_o = 1'b0;
  end

endmodule

// File: rtl/jesd204b_tpl_rx.sv
// JESD204B RX transport layer: lane octets -> converter samples/control, two-stage pipeline
// with sticky tail/padding integrity flag and a decoded-frame counter.
module jesd204b_tpl_rx
  import jesd204b_tpl_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned CONVERTERS  = 8,
  parameter int unsigned RESOLUTION  = 11,
  parameter int unsigned CONTROL     = 2,
  parameter int unsigned SAMPLE_SIZE = 16,
  parameter int unsigned SAMPLES     = 1,
  localparam int unsigned CP         = tpl_cp(LANES, CONVERTERS),
  localparam int unsigned W          = SLOT_W * CP
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [W-1:0]                     rx_datain,
  input  logic                             rx_valid,
  input  logic                             err_clr,
  output logic [CONVERTERS*RESOLUTION-1:0] rx_dataout,
  output logic [CONVERTERS*CONTROL-1:0]    rx_ctrl,
  output logic                             rx_valid_out,
  output logic                             tail_err,
  output logic [15:0]                      frame_cnt
);

  localparam int unsigned OCTETS = tpl_octets(LANES, CONVERTERS);
  localparam int unsigned LANE_W = 8 * OCTETS;
  localparam int unsigned SPL    = OCTETS / 2;
  localparam int unsigned DOUT_W = CONVERTERS * RESOLUTION;
  localparam int unsigned CTRL_W = CONVERTERS * CONTROL;
  localparam int unsigned CNT_W  = 16;

  if (!tpl_params_legal(LANES, CONVERTERS, RESOLUTION, CONTROL, SAMPLE_SIZE, SAMPLES)) begin : g_bad_params
    $error("jesd204b_tpl_rx: illegal transport-layer parameter set");
  end

  logic [W-1:0]      s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DOUT_W-1:0] samp_c, dout_q, dout_d;
  logic [CTRL_W-1:0] ctrl_c, ctrl_q, ctrl_d;
  logic [CP-1:0]     slot_err_c;
  logic              vo_q, vo_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Slot k lives in lane k/SPL; slot 0 holds the two most significant octets of the lane
  for (genvar k = 0; k < CP; k++) begin : g_slot
    localparam int unsigned LSB = (k / SPL) * LANE_W + 8 * (OCTETS - 2 - 2 * (k % SPL));
    logic [RESOLUTION-1:0] samp;
    logic [CONTROL-1:0]    ctl;
    logic                  tnz;

    jesd204b_tpl_rx_slot #(
      .RESOLUTION (RESOLUTION),
      .CONTROL    (CONTROL),
      .PAD        (k >= CONVERTERS)
    ) u_slot (
      .slot_i    (s1_data_q[LSB +: SLOT_W]),
      .sample_o  (samp),
      .ctrl_o    (ctl),
      .tail_nz_o (tnz)
    );

    if (k < CONVERTERS) begin : g_conv
      assign samp_c[k*RESOLUTION +: RESOLUTION] = samp;
      assign ctrl_c[k*CONTROL +: CONTROL]       = ctl;
      assign slot_err_c[k]                      = tnz;
    end else begin : g_pad
      assign slot_err_c[k] = tnz | (|samp) | (|ctl);
    end
  end

  // Next state; a new error takes priority over err_clr
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = rx_valid;
    dout_d     = dout_q;
    ctrl_d     = ctrl_q;
    vo_d       = s1_valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (rx_valid) s1_data_d = rx_datain;
    if (err_clr) err_d = 1'b0;
    if (s1_valid_q) begin
      dout_d = samp_c;
      ctrl_d = ctrl_c;
      cnt_d  = cnt_q + CNT_W'(1);
      if (|slot_err_c) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      dout_q     <= '0;
      ctrl_q     <= '0;
      vo_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      dout_q     <= dout_d;
      ctrl_q     <= ctrl_d;
      vo_q       <= vo_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rx_dataout   = dout_q;
  assign rx_ctrl      = ctrl_q;
  assign rx_valid_out = vo_q;
  assign tail_err     = err_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_jesd204b_tpl_rx.sv
// Bench for jesd204b_tpl_rx: an 8-converter and a 6-converter (padded) instance share one stimulus
// stream; frames are built by a TX-side packer and checked against a frame-level reference model.
module tb_jesd204b_tpl_rx;

  typedef struct packed {
    logic [7:0][10:0] s;
    logic [7:0][1:0]  c;
    logic [7:0][2:0]  t;
  } desc_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] rx_datain;
  logic         rx_valid;
  logic         err_clr;

  logic [87:0] dout8;
  logic [15:0] ctrl8;
  logic        vo8, err8, vo6, err6;
  logic [15:0] cnt8, cnt6;
  logic [65:0] dout6;
  logic [11:0] ctrl6;

  int checks   = 0;
  int failures = 0;

  // Reference-model state
  logic [87:0] exp_d8;
  logic [15:0] exp_c8;
  logic [65:0] exp_d6;
  logic [11:0] exp_c6;
  logic        exp_vo, exp_e8, exp_e6;
  logic [15:0] exp_cnt;
  desc_t       prev;
  bit          prev_v;

  jesd204b_tpl_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_valid(rx_valid), .err_clr(err_clr),
    .rx_dataout(dout8), .rx_ctrl(ctrl8), .rx_valid_out(vo8), .tail_err(err8), .frame_cnt(cnt8)
  );

  jesd204b_tpl_rx #(.CONVERTERS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .rx_datain(rx_datain), .rx_valid(rx_valid), .err_clr(err_clr),
    .rx_dataout(dout6), .rx_ctrl(ctrl6), .rx_valid_out(vo6), .tail_err(err6), .frame_cnt(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TX transport mapping: converter k -> lane k/2, slot k%2; octet 0 is the lane MSB octet
  function automatic logic [127:0] tx_pack(input desc_t d);
    logic [127:0] f;
    logic [15:0]  w;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      w = {d.s[k], d.c[k], d.t[k]};
      f[(k/2)*32 + 8*(3-2*(k%2)) +: 8] = w[15:8];
      f[(k/2)*32 + 8*(2-2*(k%2)) +: 8] = w[7:0];
    end
    return f;
  endfunction

  function automatic bit bad8(input desc_t d);
    return |d.t;
  endfunction

  function automatic bit bad6(input desc_t d);
    return (|d.t[5:0]) | (|d.s[7:6]) | (|d.c[7:6]) | (|d.t[7:6]);
  endfunction

  function automatic desc_t rand_desc(input bit clean6);
    desc_t d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      if (!clean6 || k < 6) begin
        d.s[k] = 11'($urandom);
        d.c[k] = 2'($urandom);
      end
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("dout8", 128'(dout8), 128'(exp_d8));
    chk("ctrl8", 128'(ctrl8), 128'(exp_c8));
    chk("vo8",   128'(vo8),   128'(exp_vo));
    chk("err8",  128'(err8),  128'(exp_e8));
    chk("cnt8",  128'(cnt8),  128'(exp_cnt));
    chk("dout6", 128'(dout6), 128'(exp_d6));
    chk("ctrl6", 128'(ctrl6), 128'(exp_c6));
    chk("vo6",   128'(vo6),   128'(exp_vo));
    chk("err6",  128'(err6),  128'(exp_e6));
    chk("cnt6",  128'(cnt6),  128'(exp_cnt));
  endtask

  // One clock: drive inputs, advance, update model (output = frame presented one step earlier)
  task automatic step(input desc_t d, input bit v, input bit clr, input bit rst_low, input bit do_chk);
    rx_datain = tx_pack(d);
    rx_valid  = v;
    err_clr   = clr;
    rst_n     = !rst_low;
    @(posedge clk);
    if (rst_low) begin
      exp_d8 = '0; exp_c8 = '0; exp_d6 = '0; exp_c6 = '0;
      exp_vo = 1'b0; exp_e8 = 1'b0; exp_e6 = 1'b0; exp_cnt = '0;
      prev = '0; prev_v = 1'b0;
    end else begin
      exp_vo = prev_v;
      if (prev_v) begin
        exp_d8 = prev.s;
        exp_c8 = prev.c;
        exp_d6 = prev.s[5:0];
        exp_c6 = prev.c[5:0];
        exp_cnt = exp_cnt + 16'd1;
      end
      if (prev_v && bad8(prev)) exp_e8 = 1'b1;
      else if (clr)             exp_e8 = 1'b0;
      if (prev_v && bad6(prev)) exp_e6 = 1'b1;
      else if (clr)             exp_e6 = 1'b0;
      prev   = d;
      prev_v = v;
    end
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    desc_t z, d;
    z = '0;
    prev = '0; prev_v = 1'b0;

    // Reset state
    step(z, 1'b1, 1'b0, 1'b1, 1'b1);
    step(z, 1'b0, 1'b0, 1'b1, 1'b1);

    // Converter 0 = 0x5A3, ctrl 0 (lane 0 octets B4/60)
    d = '0; d.s[0] = 11'h5A3;
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("lat_not_yet", 128'(vo8), 128'(0));
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c0_samp", 128'(dout8[10:0]), 128'(11'h5A3));
    chk("c0_vo", 128'(vo8), 128'(1));
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);

    // Control bits 2'b10 (low octet 0x70)
    d.c[0] = 2'b10;
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c0_ctrl", 128'(ctrl8[1:0]), 128'(2'b10));
    chk("c0_samp2", 128'(dout8[10:0]), 128'(11'h5A3));

    // Tail bit set (low octet 0x61) -> sticky error through clean frames
    d.c[0] = 2'b00; d.t[0] = 3'b001;
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    step(rand_desc(1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("tail_set", 128'(err8), 128'(1));
    step(rand_desc(1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tail_hold", 128'(err8), 128'(1));
    step(z, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tail_clr", 128'(err8), 128'(0));

    // Padding slot (converter 7 = lane 3 slot 1) nonzero: only the 6-converter instance flags it
    d = rand_desc(1'b1); d.s[7] = 11'h001;
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pad_err6", 128'(err6), 128'(1));
    chk("pad_err8", 128'(err8), 128'(0));
    step(z, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pad_clr", 128'(err6), 128'(0));
    // err_clr coincident with an erroneous frame: set wins
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("set_wins", 128'(err6), 128'(1));
    step(z, 1'b0, 1'b1, 1'b0, 1'b1);

    // Ten back-to-back random frames after a fresh reset
    step(z, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(rand_desc(1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cnt_ten", 128'(cnt8), 128'(10));
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random gaps in rx_valid, with arbitrary data on idle cycles
    for (int i = 0; i < 24; i++)
      step(rand_desc(1'b1), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step(rand_desc(1'b0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // Mid-stream reset flushes the frame in flight
    step(rand_desc(1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(rand_desc(1'b1), 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_flush_vo", 128'(vo8), 128'(0));
    chk("rst_flush_d", 128'(dout8), 128'(0));
    d = rand_desc(1'b1);
    step(d, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_rst_lat", 128'(vo8), 128'(0));
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_vo", 128'(vo8), 128'(1));
    chk("post_rst_cnt", 128'(cnt8), 128'(1));

    // Frame counter wrap
    step(z, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) step(z, 1'b1, 1'b0, 1'b0, 1'b0);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cnt_ffff", 128'(cnt8), 128'(16'hFFFF));
    step(rand_desc(1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cnt_wrap", 128'(cnt8), 128'(0));
    chk("cnt_wrap6", 128'(cnt6), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
